// File: rtl/regbank_write_arbiter.sv
// rtl/regbank_write_arbiter.sv - round-robin write-port arbiter with locked bursts for a register bank
// Optional address-error reporting is built when REGBANK_ARB_ERR_EN is defined.
module regbank_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 12,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REGS-1:0]         reg_we,
    output logic [DATA_W-1:0]           reg_wdata,
    output logic                        busy_locked
`ifdef REGBANK_ARB_ERR_EN
    ,
    output logic                        addr_err,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] addr_err_id
`endif
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {ST_ARB, ST_LOCKED} state_t;

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     owner;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     gnt_idx;
    logic                xfer;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_lock;
    logic                addr_ok;
    logic [ID_W-1:0]     ptr_inc;
    logic [NUM_REGS-1:0] we_next;

    // Grant is held at zero during reset so no requester sees a false handshake.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] cand;
        logic            found;
        grant   = '0;
        gnt_idx = '0;
        sum     = '0;
        cand    = '0;
        found   = 1'b0;
        if (rst_n) begin
            if (state == ST_LOCKED) begin
                grant[owner] = req_valid[owner];
                gnt_idx      = owner;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    sum = {1'b0, ptr} + (ID_W+1)'(k);
                    if (sum >= (ID_W+1)'(NUM_REQ))
                        sum = sum - (ID_W+1)'(NUM_REQ);
                    cand = sum[ID_W-1:0];
                    if (!found && req_valid[cand]) begin
                        found       = 1'b1;
                        grant[cand] = 1'b1;
                        gnt_idx     = cand;
                    end
                end
            end
        end
    end

    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);
    assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
    assign sel_lock  = req_lock[gnt_idx];
    assign addr_ok   = int'(sel_addr) < NUM_REGS;
    assign ptr_inc   = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        we_next = '0;
        if (xfer && addr_ok)
            we_next[sel_addr] = 1'b1;
    end

    // In LOCKED the grant index is the owner, so one update path covers both states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ARB;
            ptr         <= '0;
            owner       <= '0;
            reg_we      <= '0;
            reg_wdata   <= '0;
            busy_locked <= 1'b0;
        end else begin
            reg_we <= we_next;
            if (xfer) begin
                reg_wdata <= sel_data;
                if (sel_lock) begin
                    state       <= ST_LOCKED;
                    owner       <= gnt_idx;
                    busy_locked <= 1'b1;
                end else begin
                    state       <= ST_ARB;
                    ptr         <= ptr_inc;
                    busy_locked <= 1'b0;
                end
            end
        end
    end

`ifdef REGBANK_ARB_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err    <= 1'b0;
            addr_err_id <= '0;
        end else begin
            addr_err <= xfer && !addr_ok;
            if (xfer && !addr_ok)
                addr_err_id <= gnt_idx;
        end
    end
`else
    // Out-of-range beats are dropped without any report.
`endif

endmodule
